// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state and source encodings for the round-robin 2:1 arbiter
package mux2_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/mux2_out_reg.sv
// mux2_out_reg: single-entry output register with load, hold and drain
module mux2_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_sel   <= in_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin burst arbiter sharing one registered 2:1 select between two valid/ready sources
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sel,
  input  logic             out_ready
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  state_t         state;
  logic           prio;
  logic [CW-1:0]  beat_cnt;
  logic           can_acc, sel, acc, rel, in_last;
  logic [WIDTH-1:0] in_data;
  always_comb begin
    can_acc = !out_valid || out_ready;
    sel     = state == GNT_B ? SRC_B : SRC_A;
    a_ready = state == GNT_A && can_acc;
    b_ready = state == GNT_B && can_acc;
    acc     = (a_valid && a_ready) || (b_valid && b_ready);
    in_data = sel ? b_data : a_data;
    in_last = sel ? b_last : a_last;
    rel     = acc && (in_last || beat_cnt == CW'(MAX_BURST - 1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= SRC_A;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      state <= a_valid && (!b_valid || prio == SRC_A) ? GNT_A : b_valid ? GNT_B : IDLE;
    end else if (rel) begin
      state    <= IDLE;
      beat_cnt <= '0;
      prio     <= !sel;
    end else if (acc) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
  mux2_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );
endmodule
